// File: rtl/meas_pkg.sv
// Shared definitions for the multi-channel measurement counter.
//   - meas_state_t : measurement FSM state encoding
//   - EM_*         : edge_mode encodings for the ch1..NCH-1 edge counters
//   - sat_inc()    : saturating-increment step (increment enable + overflow flag)
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COUNT,
        ST_DRAIN,
        ST_HOLD
    } meas_state_t;

    localparam logic [1:0] EM_RISE = 2'b00;
    localparam logic [1:0] EM_FALL = 2'b01;
    localparam logic [1:0] EM_BOTH = 2'b10;

    typedef struct packed {
        logic inc;  // counter may advance by one
        logic ovf;  // event arrived while the counter was already all-ones
    } sat_step_t;

    // Width-independent: the caller supplies the all-ones test of its counter.
    function automatic sat_step_t sat_inc(input logic i_event, input logic i_at_max);
        sat_step_t s;
        s.inc = i_event & ~i_at_max;
        s.ovf = i_event &  i_at_max;
        return s;
    endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Input synchroniser and edge detector for one asynchronous channel.
// Ports:
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_sig        : asynchronous input pin
//   o_lvl        : synchronised level, time-aligned with o_rise/o_fall
//   o_rise       : one-cycle pulse, SYNC_STAGES+1 cycles after a rising pin transition
//   o_fall       : one-cycle pulse, SYNC_STAGES+1 cycles after a falling pin transition
module edge_sync_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Pulses are registered alongside r_lvl so the level seen with a
    // pulse is already the post-edge level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_lvl  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_lvl  <= w_sync_out;
            r_rise <= w_sync_out & ~r_lvl;
            r_fall <= ~w_sync_out & r_lvl;
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/multi_ch_meas_cnt.sv
// Gate-aligned multi-channel measurement counter (equal-precision method).
// The window opens and closes on synchronised ch0 rising edges; reference
// clocks, per-channel edges, ch0-vs-chk lead/lag events and XOR cycles are
// counted with saturation and handed over as an atomic snapshot (valid/ack).
// Optional build macro: MEAS_TIMEOUT_EN (ARMED/DRAIN timeout forcing a snapshot).
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   gate_en     : measurement window request (level)
//   clr         : synchronous abort of a running measurement
//   edge_mode   : edge select for ch1..NCH-1 edge counters
//   sig_in      : asynchronous signals under test, ch0 is the reference
//   snap_ack    : readout consumed the snapshot
//   snap_valid  : snapshot holds a completed measurement
//   ref_cnt, edge_cnt, lead_cnt, lag_cnt, xor_cnt : snapshot fields
//   snap_ovf    : a counter saturated in the snapshotted window
//   timeout     : snapshot was forced by timeout
module multi_ch_meas_cnt
    import meas_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned CW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TO_CYC      = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gate_en,
    input  logic                  clr,
    input  logic [1:0]            edge_mode,
    input  logic [NCH-1:0]        sig_in,
    input  logic                  snap_ack,
    output logic                  snap_valid,
    output logic [CW-1:0]         ref_cnt,
    output logic [NCH*CW-1:0]     edge_cnt,
    output logic [(NCH-1)*CW-1:0] lead_cnt,
    output logic [(NCH-1)*CW-1:0] lag_cnt,
    output logic [(NCH-1)*CW-1:0] xor_cnt,
    output logic                  snap_ovf,
    output logic                  timeout
);

    // All counters live in one array: ref, edge[NCH], lead[NCH-1], lag[NCH-1], xor[NCH-1].
    localparam int unsigned IDX_REF  = 0;
    localparam int unsigned IDX_EDGE = 1;
    localparam int unsigned IDX_LEAD = IDX_EDGE + NCH;
    localparam int unsigned IDX_LAG  = IDX_LEAD + NCH - 1;
    localparam int unsigned IDX_XOR  = IDX_LAG + NCH - 1;
    localparam int unsigned NCNT     = IDX_XOR + NCH - 1;

    logic [NCH-1:0] w_lvl;
    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_fall;
    logic [NCH-1:0] w_sel;

    meas_state_t r_state;
    meas_state_t w_state_nxt;

    logic w_take;   // copy live counters to the snapshot this cycle
    logic w_zero;   // clear live counters and sticky overflow
    logic w_win;    // ref/xor window: start-edge cycle counted, end-edge cycle not
    logic w_act;    // COUNT or DRAIN
    logic w_to_hit;

    logic [CW-1:0] r_live     [NCNT];
    logic [CW-1:0] w_live_nxt [NCNT];
    logic [CW-1:0] r_snap     [NCNT];
    sat_step_t     w_step     [NCNT];
    logic [NCNT-1:0] w_ev;
    logic            r_ovf;
    logic            w_ovf_nxt;
    logic            r_snap_ovf;
    logic            r_snap_valid;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        edge_sync_det #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk (clk),
            .i_rst (rst),
            .i_sig (sig_in[c]),
            .o_lvl (w_lvl[c]),
            .o_rise(w_rise[c]),
            .o_fall(w_fall[c])
        );
    end

    // ch0 always counts rising edges; other channels follow edge_mode.
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (i == 0) begin
                w_sel[i] = w_rise[i];
            end else begin
                case (edge_mode)
                    EM_RISE: w_sel[i] = w_rise[i];
                    EM_FALL: w_sel[i] = w_fall[i];
                    EM_BOTH: w_sel[i] = w_rise[i] | w_fall[i];
                    default: w_sel[i] = w_rise[i];
                endcase
            end
        end
    end

`ifdef MEAS_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TO_CYC) + 1;

    logic [TOW-1:0] r_to_cnt;
    logic           r_timeout;
    logic           w_take_to;

    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt != r_state)) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_ARMED) || (r_state == ST_DRAIN)) begin
            r_to_cnt <= r_to_cnt + TOW'(1);
        end
    end

    assign w_to_hit = (r_to_cnt == TOW'(TO_CYC - 1));
    // Any take other than the DRAIN end edge comes from the timeout.
    assign w_take_to = w_take & ~((r_state == ST_DRAIN) & w_rise[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_take) begin
            r_timeout <= w_take_to;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_zero      = 1'b0;
        w_win       = 1'b0;
        w_act       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_zero = 1'b1;
                end else if (gate_en) begin
                    w_state_nxt = ST_ARMED;
                    w_zero      = 1'b1;
                end
            end
            ST_ARMED: begin
                if (clr) begin
                    w_state_nxt = ST_IDLE;
                    w_zero      = 1'b1;
                end else if (!gate_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise[0]) begin
                    w_state_nxt = ST_COUNT;
                    w_win       = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_HOLD;
                    w_take      = 1'b1;
                end
            end
            ST_COUNT: begin
                w_act = 1'b1;
                w_win = 1'b1;
                if (clr) begin
                    w_state_nxt = ST_IDLE;
                    w_zero      = 1'b1;
                end else if (!gate_en) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_act = 1'b1;
                w_win = ~w_rise[0];
                if (clr) begin
                    w_state_nxt = ST_IDLE;
                    w_zero      = 1'b1;
                end else if (w_rise[0] || w_to_hit) begin
                    w_state_nxt = ST_HOLD;
                    w_take      = 1'b1;
                end
            end
            ST_HOLD: begin
                if (snap_ack && r_snap_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ev = '0;
        w_ev[IDX_REF] = w_win;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_ev[IDX_EDGE + i] = w_act & w_sel[i];
        end
        for (int unsigned k = 1; k < NCH; k++) begin
            w_ev[IDX_LEAD + k - 1] = w_act & w_rise[0] & w_lvl[k];
            w_ev[IDX_LAG  + k - 1] = w_act & w_rise[k] & w_lvl[0];
            w_ev[IDX_XOR  + k - 1] = w_win & (w_lvl[0] ^ w_lvl[k]);
        end
    end

    always_comb begin
        w_ovf_nxt = r_ovf;
        for (int unsigned i = 0; i < NCNT; i++) begin
            w_step[i]     = sat_inc(w_ev[i], &r_live[i]);
            w_live_nxt[i] = r_live[i] + CW'(w_step[i].inc);
            w_ovf_nxt     = w_ovf_nxt | w_step[i].ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
            for (int unsigned i = 0; i < NCNT; i++) begin
                r_live[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_zero) begin
                r_ovf <= 1'b0;
                for (int unsigned i = 0; i < NCNT; i++) begin
                    r_live[i] <= '0;
                end
            end else begin
                r_ovf <= w_ovf_nxt;
                for (int unsigned i = 0; i < NCNT; i++) begin
                    r_live[i] <= w_live_nxt[i];
                end
            end
        end
    end

    // Snapshot captures the post-update values so the closing edge is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_valid <= 1'b0;
            r_snap_ovf   <= 1'b0;
            for (int unsigned i = 0; i < NCNT; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_take) begin
            r_snap_valid <= 1'b1;
            r_snap_ovf   <= w_ovf_nxt;
            for (int unsigned i = 0; i < NCNT; i++) begin
                r_snap[i] <= w_live_nxt[i];
            end
        end else if ((r_state == ST_HOLD) && snap_ack && r_snap_valid) begin
            r_snap_valid <= 1'b0;
        end
    end

    assign snap_valid = r_snap_valid;
    assign snap_ovf   = r_snap_ovf;
    assign ref_cnt    = r_snap[IDX_REF];

    for (genvar c = 0; c < NCH; c++) begin : g_edge_out
        assign edge_cnt[c*CW +: CW] = r_snap[IDX_EDGE + c];
    end

    for (genvar k = 1; k < NCH; k++) begin : g_pair_out
        assign lead_cnt[(k-1)*CW +: CW] = r_snap[IDX_LEAD + k - 1];
        assign lag_cnt [(k-1)*CW +: CW] = r_snap[IDX_LAG  + k - 1];
        assign xor_cnt [(k-1)*CW +: CW] = r_snap[IDX_XOR  + k - 1];
    end

endmodule
